// File: rtl/param_cu_pkg.sv
// Shared encodings for the parametrised instruction sequencer:
// opclasses, FSM states, bus-source codes and ALU modes.
package param_cu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_LDI   = 4'd1,
    OP_LDM   = 4'd2,
    OP_STM   = 4'd3,
    OP_MVAR  = 4'd4,
    OP_MVRA  = 4'd5,
    OP_ADD   = 4'd6,
    OP_SUB   = 4'd7,
    OP_MUL   = 4'd8,
    OP_CLRAC = 4'd9,
    OP_INCAC = 4'd10,
    OP_JPNZ  = 4'd11,
    OP_JPZ   = 4'd12,
    OP_LDAR  = 4'd13,
    OP_RSVD  = 4'd14,
    OP_HALT  = 4'd15
  } opclass_e;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_F1     = 4'd1,
    S_F2     = 4'd2,
    S_F3     = 4'd3,
    S_E1     = 4'd4,
    S_E2     = 4'd5,
    S_E3     = 4'd6,
    S_E4     = 4'd7,
    S_E5     = 4'd8,
    S_HALTED = 4'd9
  } state_e;

  localparam int unsigned BUS_IMEM = 32'd0;
  localparam int unsigned BUS_DMEM = 32'd1;
  localparam int unsigned BUS_PC   = 32'd2;
  localparam int unsigned BUS_DR   = 32'd3;
  localparam int unsigned BUS_AC   = 32'd4;
  localparam int unsigned R_BASE   = 32'd8;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_MUL  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd4;

  // Opclasses whose low nibble names a general register.
  function automatic logic uses_reg(input opclass_e op);
    case (op)
      OP_MVAR, OP_MVRA, OP_ADD, OP_SUB, OP_MUL, OP_LDAR: uses_reg = 1'b1;
      default:                                           uses_reg = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/param_control_unit.sv
// Instruction sequencer: fetch/decode/execute FSM driving datapath strobes,
// with mem_ready stretching, start/done handshake and illegal-register flag.
module param_control_unit
  import param_cu_pkg::*;
#(
  parameter  int NUM_REGS = 8,
  localparam int SEL_W    = $clog2(NUM_REGS + 8)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          ir,
  input  logic                z,
  input  logic                mem_ready,
  output logic                ar_we,
  output logic                pc_we,
  output logic                dr_we,
  output logic                ir_we,
  output logic                ac_we,
  output logic [NUM_REGS-1:0] reg_we,
  output logic                pc_inc,
  output logic                ac_inc,
  output logic                ac_clr,
  output logic                pc_clr,
  output logic [SEL_W-1:0]    bus_sel,
  output logic [2:0]          alu_mode,
  output logic                dm_wr,
  output logic                busy,
  output logic                done,
  output logic                illegal
);

  state_e     state_q, state_d;
  opclass_e   op_s;
  logic [3:0] n_s;
  logic       reg_ok_s;
  logic       taken_s;
  logic       is_jump_s;

  // Instruction field decode.
  always_comb begin
    op_s      = opclass_e'(ir[7:4]);
    n_s       = ir[3:0];
    reg_ok_s  = (32'(n_s) < 32'(NUM_REGS));
    is_jump_s = (op_s == OP_JPNZ) || (op_s == OP_JPZ);
    taken_s   = (op_s == OP_JPNZ) ? ~z : z;
  end

  // Next state and state-decoded outputs; reset forces the quiet defaults.
  always_comb begin
    state_d  = state_q;
    ar_we    = 1'b0;
    pc_we    = 1'b0;
    dr_we    = 1'b0;
    ir_we    = 1'b0;
    ac_we    = 1'b0;
    reg_we   = '0;
    pc_inc   = 1'b0;
    ac_inc   = 1'b0;
    ac_clr   = 1'b0;
    pc_clr   = 1'b0;
    bus_sel  = '0;
    alu_mode = ALU_PASS;
    dm_wr    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    if (rst) begin
      state_d = S_IDLE;
    end else begin
      busy = (state_q != S_IDLE) && (state_q != S_HALTED);
      done = (state_q == S_HALTED);
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start) begin
            pc_clr  = 1'b1;
            state_d = S_F1;
          end else begin
            state_d = state_q;
          end
        end
        S_F1: begin
          bus_sel = SEL_W'(BUS_PC);
          ar_we   = 1'b1;
          state_d = S_F2;
        end
        S_F2: begin
          bus_sel = SEL_W'(BUS_IMEM);
          dr_we   = 1'b1;
          if (mem_ready) begin
            pc_inc  = 1'b1;
            state_d = S_F3;
          end else begin
            state_d = S_F2;
          end
        end
        S_F3: begin
          bus_sel = SEL_W'(BUS_DR);
          ir_we   = 1'b1;
          state_d = S_E1;
        end
        S_E1: begin
          state_d = S_F1;
          if (uses_reg(op_s) && !reg_ok_s) begin
            illegal = 1'b1;
          end else begin
            case (op_s)
              OP_LDI, OP_LDM, OP_STM: begin
                bus_sel = SEL_W'(BUS_PC);
                ar_we   = 1'b1;
                state_d = S_E2;
              end
              OP_MVAR: begin
                bus_sel = SEL_W'(BUS_AC);
                reg_we  = NUM_REGS'(1'b1) << n_s;
              end
              OP_MVRA, OP_ADD, OP_SUB, OP_MUL: begin
                bus_sel = SEL_W'(R_BASE) + SEL_W'(n_s);
                ac_we   = 1'b1;
                case (op_s)
                  OP_ADD:  alu_mode = ALU_ADD;
                  OP_SUB:  alu_mode = ALU_SUB;
                  OP_MUL:  alu_mode = ALU_MUL;
                  default: alu_mode = ALU_PASS;
                endcase
              end
              OP_CLRAC: ac_clr = 1'b1;
              OP_INCAC: ac_inc = 1'b1;
              OP_JPNZ, OP_JPZ: begin
                if (taken_s) begin
                  bus_sel = SEL_W'(BUS_PC);
                  ar_we   = 1'b1;
                  state_d = S_E2;
                end else begin
                  pc_inc  = 1'b1;
                end
              end
              OP_LDAR: begin
                bus_sel = SEL_W'(R_BASE) + SEL_W'(n_s);
                ar_we   = 1'b1;
              end
              OP_HALT: state_d = S_HALTED;
              default: state_d = S_F1;
            endcase
          end
        end
        S_E2: begin
          bus_sel = SEL_W'(BUS_IMEM);
          dr_we   = 1'b1;
          if (mem_ready) begin
            pc_inc  = ~is_jump_s;
            state_d = S_E3;
          end else begin
            state_d = S_E2;
          end
        end
        S_E3: begin
          bus_sel = SEL_W'(BUS_DR);
          case (op_s)
            OP_LDI: begin
              ac_we   = 1'b1;
              state_d = S_F1;
            end
            OP_LDM, OP_STM: begin
              ar_we   = 1'b1;
              state_d = S_E4;
            end
            OP_JPNZ, OP_JPZ: begin
              pc_we   = 1'b1;
              state_d = S_F1;
            end
            default: state_d = S_F1;
          endcase
        end
        S_E4: begin
          // STM drives AC out to memory; LDM pulls the data word into DR.
          if (op_s == OP_STM) begin
            bus_sel = SEL_W'(BUS_AC);
            dm_wr   = 1'b1;
          end else begin
            bus_sel = SEL_W'(BUS_DMEM);
            dr_we   = 1'b1;
          end
          if (mem_ready) begin
            state_d = (op_s == OP_STM) ? S_F1 : S_E5;
          end else begin
            state_d = S_E4;
          end
        end
        S_E5: begin
          bus_sel = SEL_W'(BUS_DR);
          ac_we   = 1'b1;
          state_d = S_F1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_param_control_unit.sv
// Directed cycle-by-cycle bench for param_control_unit with NUM_REGS=8;
// each cycle's strobes, bus select, ALU mode and reg_we are hand-expected.
module tb_param_control_unit;

  localparam int NUM_REGS = 8;
  localparam int SEL_W    = $clog2(NUM_REGS + 8);

  // Strobe vector bit masks: {ar,pcw,dr,ir,ac,pci,aci,acc,pcc,dm,ill,busy,done}
  localparam logic [12:0] AR  = 13'h1000;
  localparam logic [12:0] PCW = 13'h0800;
  localparam logic [12:0] DRW = 13'h0400;
  localparam logic [12:0] IRW = 13'h0200;
  localparam logic [12:0] ACW = 13'h0100;
  localparam logic [12:0] PCI = 13'h0080;
  localparam logic [12:0] ACI = 13'h0040;
  localparam logic [12:0] ACC = 13'h0020;
  localparam logic [12:0] PCC = 13'h0010;
  localparam logic [12:0] DMW = 13'h0008;
  localparam logic [12:0] ILL = 13'h0004;
  localparam logic [12:0] BSY = 13'h0002;
  localparam logic [12:0] DN  = 13'h0001;

  logic                clk, rst, start, z, mem_ready;
  logic [7:0]          ir;
  logic                ar_we, pc_we, dr_we, ir_we, ac_we;
  logic [NUM_REGS-1:0] reg_we;
  logic                pc_inc, ac_inc, ac_clr, pc_clr;
  logic [SEL_W-1:0]    bus_sel;
  logic [2:0]          alu_mode;
  logic                dm_wr, busy, done, illegal;

  int n_checks = 0;
  int n_bad    = 0;
  int inc_cnt  = 0;

  param_control_unit #(.NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst), .start(start), .ir(ir), .z(z), .mem_ready(mem_ready),
    .ar_we(ar_we), .pc_we(pc_we), .dr_we(dr_we), .ir_we(ir_we), .ac_we(ac_we),
    .reg_we(reg_we), .pc_inc(pc_inc), .ac_inc(ac_inc), .ac_clr(ac_clr),
    .pc_clr(pc_clr), .bus_sel(bus_sel), .alu_mode(alu_mode), .dm_wr(dm_wr),
    .busy(busy), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one cycle's outputs after inputs settle, then advance to the next cycle.
  task automatic exp_cyc(input string tag, input logic [12:0] es, input int eb,
                         input int ea, input logic [7:0] er);
    logic [12:0] st;
    #2;
    st = {ar_we, pc_we, dr_we, ir_we, ac_we, pc_inc, ac_inc, ac_clr, pc_clr,
          dm_wr, illegal, busy, done};
    if (pc_inc) inc_cnt++;
    chk({tag, ".strb"}, 32'(st), 32'(es));
    chk({tag, ".bus"}, 32'(bus_sel), 32'(eb));
    chk({tag, ".alu"}, 32'(alu_mode), 32'(ea));
    chk({tag, ".reg"}, 32'(reg_we), 32'(er));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag);
    exp_cyc({tag, ".f1"}, AR | BSY, 2, 4, 8'h00);
    exp_cyc({tag, ".f2"}, DRW | PCI | BSY, 0, 4, 8'h00);
    exp_cyc({tag, ".f3"}, IRW | BSY, 3, 4, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b1; ir = 8'h00; z = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    // Reset beats a simultaneous start.
    exp_cyc("rst0", 13'h0, 0, 4, 8'h00);
    exp_cyc("rst1", 13'h0, 0, 4, 8'h00);
    rst = 1'b0; start = 1'b0;
    exp_cyc("idle", 13'h0, 0, 4, 8'h00);
    start = 1'b1;
    exp_cyc("start", PCC, 0, 4, 8'h00);
    start = 1'b0;

    // LDI 0x2A: six cycles, two pc_inc pulses, ac_we with bus DR in cycle 6.
    ir = 8'h10; inc_cnt = 0;
    fetch("ldi");
    exp_cyc("ldi.e1", AR | BSY, 2, 4, 8'h00);
    exp_cyc("ldi.e2", DRW | PCI | BSY, 0, 4, 8'h00);
    exp_cyc("ldi.e3", ACW | BSY, 3, 4, 8'h00);
    chk("ldi.inc", 32'(inc_cnt), 32'd2);

    ir = 8'h43;
    fetch("mvar3");
    exp_cyc("mvar3.e1", BSY, 4, 4, 8'b0000_1000);

    ir = 8'h49;
    fetch("mvar9");
    exp_cyc("mvar9.e1", ILL | BSY, 0, 4, 8'h00);

    // ADD R2, with a start pulse during fetch that must be ignored.
    ir = 8'h62; start = 1'b1;
    fetch("add");
    start = 1'b0;
    exp_cyc("add.e1", ACW | BSY, 10, 0, 8'h00);
    ir = 8'h75;
    fetch("sub");
    exp_cyc("sub.e1", ACW | BSY, 13, 1, 8'h00);
    ir = 8'h81;
    fetch("mul");
    exp_cyc("mul.e1", ACW | BSY, 9, 2, 8'h00);
    ir = 8'h90;
    fetch("clr");
    exp_cyc("clr.e1", ACC | BSY, 0, 4, 8'h00);
    ir = 8'hD6;
    fetch("ldar");
    exp_cyc("ldar.e1", AR | BSY, 14, 4, 8'h00);

    // STM with three wait cycles in E4.
    ir = 8'h30;
    fetch("stm");
    exp_cyc("stm.e1", AR | BSY, 2, 4, 8'h00);
    exp_cyc("stm.e2", DRW | PCI | BSY, 0, 4, 8'h00);
    exp_cyc("stm.e3", AR | BSY, 3, 4, 8'h00);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) exp_cyc("stm.e4w", DMW | BSY, 4, 4, 8'h00);
    mem_ready = 1'b1;
    exp_cyc("stm.e4", DMW | BSY, 4, 4, 8'h00);

    // Taken JPNZ (z=0) with one wait cycle in F2 and none in E2.
    ir = 8'hB0; z = 1'b0;
    exp_cyc("jt.f1", AR | BSY, 2, 4, 8'h00);
    mem_ready = 1'b0;
    exp_cyc("jt.f2w", DRW | BSY, 0, 4, 8'h00);
    mem_ready = 1'b1;
    exp_cyc("jt.f2", DRW | PCI | BSY, 0, 4, 8'h00);
    exp_cyc("jt.f3", IRW | BSY, 3, 4, 8'h00);
    exp_cyc("jt.e1", AR | BSY, 2, 4, 8'h00);
    exp_cyc("jt.e2", DRW | BSY, 0, 4, 8'h00);
    exp_cyc("jt.e3", PCW | BSY, 3, 4, 8'h00);

    // Untaken JPNZ (z=1).
    z = 1'b1;
    fetch("jn");
    exp_cyc("jn.e1", PCI | BSY, 0, 4, 8'h00);
    z = 1'b0;

    ir = 8'hF0;
    fetch("halt");
    exp_cyc("halt.e1", BSY, 0, 4, 8'h00);
    exp_cyc("halted0", DN, 0, 4, 8'h00);
    exp_cyc("halted1", DN, 0, 4, 8'h00);
    start = 1'b1;
    exp_cyc("restart", PCC | DN, 0, 4, 8'h00);
    start = 1'b0;

    // LDM abandoned by reset while waiting in E4.
    ir = 8'h20;
    fetch("ldm");
    exp_cyc("ldm.e1", AR | BSY, 2, 4, 8'h00);
    exp_cyc("ldm.e2", DRW | PCI | BSY, 0, 4, 8'h00);
    exp_cyc("ldm.e3", AR | BSY, 3, 4, 8'h00);
    mem_ready = 1'b0;
    exp_cyc("ldm.e4w", DRW | BSY, 1, 4, 8'h00);
    rst = 1'b1;
    exp_cyc("ldm.rst", 13'h0, 0, 4, 8'h00);
    rst = 1'b0; mem_ready = 1'b1;
    exp_cyc("ldm.idle0", 13'h0, 0, 4, 8'h00);
    exp_cyc("ldm.idle1", 13'h0, 0, 4, 8'h00);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
